// File: rtl/instr_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// instr_fetch_ctrl : single-outstanding instruction fetch sequencer feeding a
//                    halfword-granular fetch queue.          Revision: 1.0
// ============================================================================
module instr_fetch_ctrl #(
  parameter logic [31:0] RESET_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        fetch_en,
  input  logic        jump,
  input  logic [31:0] jump_addr,
  output logic        ibus_req,
  output logic [31:0] ibus_addr,
  input  logic        ibus_gnt,
  input  logic        ibus_rvalid,
  input  logic [31:0] ibus_rdata,
  output logic        q_in_req,
  output logic        q_in_16bit,
  output logic [31:0] q_in,
  output logic        q_clr,
  input  logic [1:0]  q_vacant,
  output logic [31:0] fetch_pc
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_REQ     = 2'd1,
    S_WAIT    = 2'd2,
    S_DISCARD = 2'd3
  } state_t;

  localparam logic [31:0] C_HALF_MASK = 32'hFFFF_FFFE;
  localparam logic [31:0] C_RESET_PC  = RESET_ADDR & C_HALF_MASK;

  state_t      r_state;
  state_t      w_next_state;
  logic [31:0] r_pc;
  logic [31:0] w_next_pc;
  logic        w_write;
  logic        w_vacant_ok;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= S_IDLE;
      r_pc    <= C_RESET_PC;
    end else begin
      r_state <= w_next_state;
      r_pc    <= w_next_pc;
    end
  end

  // An unaligned pc only needs room for the upper halfword of the word.
  assign w_vacant_ok = r_pc[1] ? (q_vacant != 2'd0) : (q_vacant >= 2'd2);

  always_comb begin
    w_next_state = r_state;
    w_write      = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (!jump && fetch_en && w_vacant_ok) w_next_state = S_REQ;
      end
      S_REQ: begin
        if (jump)          w_next_state = ibus_gnt ? S_DISCARD : S_IDLE;
        else if (ibus_gnt) w_next_state = S_WAIT;
      end
      S_WAIT: begin
        if (jump) begin
          w_next_state = ibus_rvalid ? S_IDLE : S_DISCARD;
        end else if (ibus_rvalid) begin
          w_next_state = S_IDLE;
          w_write      = 1'b1;
        end
      end
      S_DISCARD: begin
        if (ibus_rvalid) w_next_state = S_IDLE;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  always_comb begin
    w_next_pc = r_pc;
    if (jump)         w_next_pc = jump_addr & C_HALF_MASK;
    else if (w_write) w_next_pc = r_pc + (r_pc[1] ? 32'd2 : 32'd4);
  end

  always_comb begin
    ibus_req   = (r_state == S_REQ);
    ibus_addr  = ibus_req ? {r_pc[31:2], 2'b00} : 32'h0000_0000;
    q_in_req   = w_write;
    q_in_16bit = w_write & r_pc[1];
    q_in       = 32'h0000_0000;
    if (w_write) q_in = r_pc[1] ? {16'h0000, ibus_rdata[31:16]} : ibus_rdata;
    // Held low while in reset even if a jump strobe is present.
    q_clr      = jump & rstn;
    fetch_pc   = r_pc;
  end

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// tb_instr_fetch_ctrl : scoreboard bench for instr_fetch_ctrl.  Revision: 1.0
// ============================================================================
module tb_instr_fetch_ctrl;

  localparam logic [31:0] C_RESET_ADDR = 32'h0000_0101;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        fetch_en = 1'b0;
  logic        jump = 1'b0;
  logic [31:0] jump_addr = 32'h0;
  logic        ibus_gnt = 1'b0;
  logic        ibus_rvalid = 1'b0;
  logic [31:0] ibus_rdata = 32'h0;
  logic [1:0]  q_vacant = 2'd2;
  logic        ibus_req;
  logic [31:0] ibus_addr;
  logic        q_in_req;
  logic        q_in_16bit;
  logic [31:0] q_in;
  logic        q_clr;
  logic [31:0] fetch_pc;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic        is16;
    logic [31:0] data;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  logic [31:0] m_pc = 32'h0;
  logic        mon_en = 1'b0;

  instr_fetch_ctrl #(.RESET_ADDR(C_RESET_ADDR)) dut (
    .clk(clk), .rstn(rstn), .fetch_en(fetch_en), .jump(jump), .jump_addr(jump_addr),
    .ibus_req(ibus_req), .ibus_addr(ibus_addr), .ibus_gnt(ibus_gnt),
    .ibus_rvalid(ibus_rvalid), .ibus_rdata(ibus_rdata), .q_in_req(q_in_req),
    .q_in_16bit(q_in_16bit), .q_in(q_in), .q_clr(q_clr), .q_vacant(q_vacant),
    .fetch_pc(fetch_pc)
  );

  always #5 clk = ~clk;

  // Queue-write monitor: every write must match the oldest expected entry.
  always @(negedge clk) begin
    if (mon_en && rstn) begin
      checks++;
      if (q_in_req === 1'b1) begin
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_write: got q_in=%h 16bit=%b, required no write", q_in, q_in_16bit);
        end else begin
          mon_e = sb.pop_front();
          if ({q_in_16bit, q_in} !== {mon_e.is16, mon_e.data}) begin
            errors++;
            $display("FAIL queue_write: got 16bit=%b q_in=%h, required 16bit=%b q_in=%h",
                     q_in_16bit, q_in, mon_e.is16, mon_e.data);
          end
        end
      end else if ({q_in_16bit, q_in} !== 33'd0) begin
        errors++;
        $display("FAIL idle_q_in: got 16bit=%b q_in=%h, required 0", q_in_16bit, q_in);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Waits for a request, grants it, returns read data one cycle later.
  task automatic bus_txn(input logic [31:0] rdata, input int gnt_delay,
                         output bit got, output logic [31:0] addr, output int waited);
    exp_t e;
    got = 1'b0;
    addr = 32'h0;
    waited = 0;
    while (waited < 20 && ibus_req !== 1'b1) begin
      step();
      waited++;
    end
    if (ibus_req !== 1'b1) return;
    got = 1'b1;
    addr = ibus_addr;
    repeat (gnt_delay) step();
    ibus_gnt = 1'b1;
    step();
    ibus_gnt = 1'b0;
    e.is16 = m_pc[1];
    e.data = m_pc[1] ? {16'h0000, rdata[31:16]} : rdata;
    sb.push_back(e);
    m_pc = m_pc + (m_pc[1] ? 32'd2 : 32'd4);
    ibus_rvalid = 1'b1;
    ibus_rdata = rdata;
    step();
    ibus_rvalid = 1'b0;
    ibus_rdata = 32'h0;
  endtask

  task automatic wait_req();
    for (int i = 0; i < 20 && ibus_req !== 1'b1; i++) step();
  endtask

  task automatic test_reset();
    repeat (2) step();
    rstn = 1'b1;
    step();
    fetch_en = 1'b1;
    jump = 1'b1;
    jump_addr = 32'h1234_5678;
    step();
    #2 rstn = 1'b0;
    #1;
    checks++; if (ibus_req !== 1'b0) begin errors++; $display("FAIL reset_ibus_req: got %b required 0", ibus_req); end
    checks++; if (ibus_addr !== 32'h0) begin errors++; $display("FAIL reset_ibus_addr: got %h required 0", ibus_addr); end
    checks++; if (q_in_req !== 1'b0) begin errors++; $display("FAIL reset_q_in_req: got %b required 0", q_in_req); end
    checks++; if (q_in_16bit !== 1'b0) begin errors++; $display("FAIL reset_q_in_16bit: got %b required 0", q_in_16bit); end
    checks++; if (q_in !== 32'h0) begin errors++; $display("FAIL reset_q_in: got %h required 0", q_in); end
    checks++; if (q_clr !== 1'b0) begin errors++; $display("FAIL reset_q_clr: got %b required 0", q_clr); end
    checks++; if (fetch_pc !== 32'h100) begin errors++; $display("FAIL reset_pc: got %h required 00000100", fetch_pc); end
    jump = 1'b0;
    step();
    rstn = 1'b1;
    m_pc = 32'h100;
    mon_en = 1'b1;
  endtask

  task automatic test_basic();
    bit got; logic [31:0] addr; int waited;
    bus_txn(32'hAABB_CCDD, 0, got, addr, waited);
    checks++; if (got !== 1'b1) begin errors++; $display("FAIL basic_req: got %b required 1", got); end
    checks++; if (addr !== 32'h100) begin errors++; $display("FAIL basic_addr: got %h required 00000100", addr); end
    checks++; if (fetch_pc !== 32'h104) begin errors++; $display("FAIL basic_pc: got %h required 00000104", fetch_pc); end
  endtask

  task automatic test_back_to_back();
    bit got; logic [31:0] addr; int waited;
    bus_txn(32'h0102_0304, 2, got, addr, waited);
    checks++; if (waited !== 1) begin errors++; $display("FAIL b2b_latency: got %0d cycles required 1", waited); end
    checks++; if (addr !== 32'h104) begin errors++; $display("FAIL b2b_addr: got %h required 00000104", addr); end
    checks++; if (fetch_pc !== 32'h108) begin errors++; $display("FAIL b2b_pc: got %h required 00000108", fetch_pc); end
  endtask

  task automatic test_jump_16bit();
    bit got; logic [31:0] addr; int waited;
    jump = 1'b1;
    jump_addr = 32'h0000_0203;
    @(negedge clk);
    checks++; if (q_clr !== 1'b1) begin errors++; $display("FAIL j16_q_clr: got %b required 1", q_clr); end
    step();
    jump = 1'b0;
    checks++; if (fetch_pc !== 32'h202) begin errors++; $display("FAIL j16_target: got %h required 00000202", fetch_pc); end
    m_pc = 32'h202;
    bus_txn(32'h1122_3344, 0, got, addr, waited);
    checks++; if (addr !== 32'h200) begin errors++; $display("FAIL j16_addr: got %h required 00000200", addr); end
    checks++; if (fetch_pc !== 32'h204) begin errors++; $display("FAIL j16_pc: got %h required 00000204", fetch_pc); end
  endtask

  task automatic test_jump_in_wait();
    bit got; logic [31:0] addr; int waited;
    wait_req();
    checks++; if (ibus_req !== 1'b1) begin errors++; $display("FAIL jw_req: got %b required 1", ibus_req); end
    ibus_gnt = 1'b1;
    step();
    ibus_gnt = 1'b0;
    jump = 1'b1;
    jump_addr = 32'h0000_0300;
    @(negedge clk);
    checks++; if (q_clr !== 1'b1) begin errors++; $display("FAIL jw_q_clr: got %b required 1", q_clr); end
    step();
    jump = 1'b0;
    checks++; if (ibus_req !== 1'b0) begin errors++; $display("FAIL jw_discard_req: got %b required 0", ibus_req); end
    ibus_rvalid = 1'b1;
    ibus_rdata = 32'hBAD0_BAD0;
    step();
    ibus_rvalid = 1'b0;
    ibus_rdata = 32'h0;
    m_pc = 32'h300;
    checks++; if (fetch_pc !== 32'h300) begin errors++; $display("FAIL jw_pc: got %h required 00000300", fetch_pc); end
    bus_txn(32'h7777_8888, 0, got, addr, waited);
    checks++; if (addr !== 32'h300) begin errors++; $display("FAIL jw_addr: got %h required 00000300", addr); end
  endtask

  task automatic test_jump_in_req();
    bit got; logic [31:0] addr; int waited;
    wait_req();
    jump = 1'b1;
    jump_addr = 32'h0000_0400;
    step();
    jump = 1'b0;
    checks++; if (ibus_req !== 1'b0) begin errors++; $display("FAIL jr_withdraw: got %b required 0", ibus_req); end
    step();
    checks++; if (ibus_req !== 1'b1) begin errors++; $display("FAIL jr_reissue: got %b required 1", ibus_req); end
    checks++; if (ibus_addr !== 32'h400) begin errors++; $display("FAIL jr_addr: got %h required 00000400", ibus_addr); end
    m_pc = 32'h400;
    bus_txn(32'h5566_7788, 0, got, addr, waited);
    checks++; if (fetch_pc !== 32'h404) begin errors++; $display("FAIL jr_pc: got %h required 00000404", fetch_pc); end
  endtask

  task automatic test_vacancy();
    bit got; logic [31:0] addr; int waited;
    q_vacant = 2'd1;
    repeat (4) step();
    checks++; if (ibus_req !== 1'b0) begin errors++; $display("FAIL vac1_aligned: got %b required 0", ibus_req); end
    fetch_en = 1'b0;
    q_vacant = 2'd2;
    repeat (3) step();
    checks++; if (ibus_req !== 1'b0) begin errors++; $display("FAIL fetch_en_off: got %b required 0", ibus_req); end
    fetch_en = 1'b1;
    q_vacant = 2'd0;
    jump = 1'b1;
    jump_addr = 32'h0000_0502;
    step();
    jump = 1'b0;
    m_pc = 32'h502;
    repeat (3) step();
    checks++; if (ibus_req !== 1'b0) begin errors++; $display("FAIL vac0: got %b required 0", ibus_req); end
    q_vacant = 2'd1;
    bus_txn(32'hCAFE_F00D, 0, got, addr, waited);
    checks++; if (got !== 1'b1) begin errors++; $display("FAIL vac1_unaligned: got %b required 1", got); end
    checks++; if (addr !== 32'h500) begin errors++; $display("FAIL vac1_addr: got %h required 00000500", addr); end
    q_vacant = 2'd2;
  endtask

  task automatic test_wrap_and_jump_on_rvalid();
    bit got; logic [31:0] addr; int waited;
    jump = 1'b1;
    jump_addr = 32'hFFFF_FFFC;
    step();
    jump = 1'b0;
    m_pc = 32'hFFFF_FFFC;
    bus_txn(32'hDEAD_BEEF, 1, got, addr, waited);
    checks++; if (addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_addr: got %h required fffffffc", addr); end
    checks++; if (fetch_pc !== 32'h0) begin errors++; $display("FAIL wrap_pc: got %h required 00000000", fetch_pc); end
    wait_req();
    ibus_gnt = 1'b1;
    step();
    ibus_gnt = 1'b0;
    ibus_rvalid = 1'b1;
    ibus_rdata = 32'h0BAD_F00D;
    jump = 1'b1;
    jump_addr = 32'h0000_0600;
    @(negedge clk);
    checks++; if ({q_clr, q_in_req} !== 2'b10) begin errors++; $display("FAIL jrv_strobes: got clr/req=%b required 10", {q_clr, q_in_req}); end
    step();
    ibus_rvalid = 1'b0;
    ibus_rdata = 32'h0;
    jump = 1'b0;
    checks++; if (fetch_pc !== 32'h600) begin errors++; $display("FAIL jrv_pc: got %h required 00000600", fetch_pc); end
    m_pc = 32'h600;
    step();
    checks++; if (ibus_req !== 1'b1) begin errors++; $display("FAIL jrv_idle: got %b required 1", ibus_req); end
    bus_txn(32'h1357_9BDF, 0, got, addr, waited);
    checks++; if (addr !== 32'h600) begin errors++; $display("FAIL jrv_addr: got %h required 00000600", addr); end
  endtask

  task automatic test_async_reset();
    bit got; logic [31:0] addr; int waited;
    wait_req();
    ibus_gnt = 1'b1;
    step();
    ibus_gnt = 1'b0;
    #2 rstn = 1'b0;
    #1;
    checks++; if (fetch_pc !== 32'h100) begin errors++; $display("FAIL areset_pc: got %h required 00000100", fetch_pc); end
    checks++; if (ibus_req !== 1'b0) begin errors++; $display("FAIL areset_req: got %b required 0", ibus_req); end
    step();
    rstn = 1'b1;
    m_pc = 32'h100;
    bus_txn(32'h2468_ACE0, 0, got, addr, waited);
    checks++; if (addr !== 32'h100) begin errors++; $display("FAIL areset_addr: got %h required 00000100", addr); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_jump_16bit();
    test_jump_in_wait();
    test_jump_in_req();
    test_vacancy();
    test_wrap_and_jump_on_rvalid();
    test_async_reset();
    step();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL missing_writes: got %0d pending entries, required 0", sb.size());
    end
    mon_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
